bcd_digit_serializer: RTL and testbench
=======================================

Name: bcd_digit_serializer

Overview:
Sequential stage directly downstream of the combinational binary-to-BCD converter. It accepts one packed BCD word (DIGIT nibbles) per transaction over a valid/ready handshake. It then emits the digits one per beat, most-significant first, with optional leading-zero suppression. The stream feeds a display/UART-style character consumer.

Parameters:
DIGIT, 2, number of BCD digits in the input word (>=1)
LZ_SUPPRESS, 1, 1 = skip leading zero digits (always keep at least digit 0); 0 = emit all DIGIT digits

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  BCD_code valid
in_ready  output  1  block can accept a word
BCD_code  input  DIGIT*4  packed BCD word; digit k = BCD_code[4k+3:4k], digit DIGIT-1 is most significant
out_valid  output  1  out_digit valid
out_ready  input  1  downstream accepts current beat
out_digit  output  4  current digit value
out_last  output  1  current beat is digit 0 (final beat)
out_err  output  1  current digit is not legal BCD (>9)

Behaviour:
- Interface: one clock (clk); synchronous, active-low reset rst_n. All outputs registered or decoded from registers only. No combinational in->out path.
- Reset (rst_n=0 at an edge): state=IDLE, shift/hold register=0, index=0. After the edge: in_ready=1, out_valid=0, out_digit=0, out_last=0, out_err=0.
- States: IDLE, SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at edge N: capture BCD_code and load index. Index = position of the most-significant non-zero digit if LZ_SUPPRESS=1 (0 if word is all zero), else DIGIT-1. Go to SEND.
  - First out_valid occurs in cycle N+1 (latency 1).
- SEND:
  - in_ready=0, out_valid=1.
  - out_digit = captured digit[index]; out_last = (index==0); out_err = (out_digit>9).
  - On out_ready=1 at an edge: if index==0, go to IDLE; else index decrements by 1.
  - out_ready=0: out_digit, out_last and out_err held stable; the held word is never modified.
- Back-to-back: in_ready rises in the cycle after the last beat is accepted. One idle bubble per word is the defined throughput; number of beats = emitted digits + 1 cycle per word.
- Illegal digits (>9) are transmitted unchanged with out_err=1. A nibble >9 counts as non-zero for leading-zero detection.
- in_valid while in SEND: ignored (in_ready=0). Upstream holds the word.
- Reset mid-SEND: current word is discarded; IDLE from the next cycle; no partial beat continues.
- DIGIT=1: index register width 1 (minimum). Every word emits exactly one beat with out_last=1.
- Index width = max(1, clog2(DIGIT)). No arithmetic wrap: index never decrements below 0.

Decomposition:
- Shared package: state encoding (IDLE, SEND) and the constant BCD_MAX=9.
- Sub-module lz_detect: combinational priority encoder returning the most-significant non-zero digit index. Generate-loop over DIGIT; instantiated once, bypassed when LZ_SUPPRESS=0.
- Remainder is one FSM + hold register + down-counter in the top module.

Test Plan:
1. DIGIT=2, LZ=1, BCD_code=8'h15, out_ready=1 -> in_ready low one edge after accept; beats 1, 5; out_last only on 5; then in_ready=1.
2. DIGIT=2, LZ=1, BCD_code=8'h07 -> single beat 7 with out_last=1. Same with 8'h00 -> single beat 0, out_last=1. With LZ=0, 8'h07 -> beats 0, 7.
3. Backpressure: 8'h93, out_ready held 0 for 5 cycles on the first beat -> out_digit=9 stable, out_last=0 throughout. Release -> beat 3, out_last=1.
4. Illegal BCD: 8'h1A -> beats 1 (out_err=0), A (out_err=1, out_last=1). Word 8'hA0, LZ=1 -> beats A (err), 0.
5. Reset mid-operation: DIGIT=4, word 16'h1234, rst_n=0 during beat 2 -> next cycle out_valid=0, in_ready=1. A new word 16'h0056 emits 5, 6 only.
6. Back-to-back: in_valid held high with 8'h42 then 8'h08 -> 4, 2(last), one bubble cycle, 8(last); no word dropped or duplicated.

Source files
------------

// File: rtl/bcd_digit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// bcd_digit_serializer_pkg
// Shared definitions for the BCD digit serializer:
//   state_t    - serializer FSM states (idle / sending digits)
//   BCD_MAX    - largest legal BCD digit value
//   idx_width  - width of a digit index for a given digit count (minimum 1)
// -----------------------------------------------------------------------------
package bcd_digit_serializer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // A single-digit word still needs a 1-bit index register.
    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/bcd_digit_serializer_lz_detect.sv
// -----------------------------------------------------------------------------
// bcd_digit_serializer_lz_detect
// Combinational priority encoder: returns the index of the most-significant
// non-zero nibble of a packed BCD word (0 when the whole word is zero).
// Any non-zero nibble counts, including illegal values above 9.
// Ports:
//   i_word  in   DIGIT*4  packed word, digit k = i_word[4k+3:4k]
//   o_idx   out  IDX_W    index of the most-significant non-zero digit
// -----------------------------------------------------------------------------
module bcd_digit_serializer_lz_detect
    import bcd_digit_serializer_pkg::*;
#(
    parameter int DIGIT = 2,
    parameter int IDX_W = idx_width(DIGIT)
) (
    input  logic [DIGIT*4-1:0] i_word,
    output logic [IDX_W-1:0]   o_idx
);

    logic [DIGIT-1:0] w_nz;

    genvar g;
    for (g = 0; g < DIGIT; g++) begin : g_nz
        assign w_nz[g] = |i_word[4*g +: 4];
    end

    // Ascending scan: the last hit is the most-significant non-zero digit.
    always_comb begin
        o_idx = '0;
        for (int k = 0; k < DIGIT; k++) begin
            if (w_nz[k]) begin
                o_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/bcd_digit_serializer.sv
// -----------------------------------------------------------------------------
// bcd_digit_serializer
// Accepts one packed BCD word per valid/ready transaction and streams its
// digits one per beat, most-significant first, optionally skipping leading
// zeros (digit 0 is always sent). Illegal nibbles (>9) pass through with
// out_err set. All outputs decode from registers only.
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        synchronous active-low reset
//   in_valid   in   1        BCD_code valid
//   in_ready   out  1        ready to accept a word (idle)
//   BCD_code   in   DIGIT*4  packed BCD word, digit DIGIT-1 most significant
//   out_valid  out  1        out_digit valid
//   out_ready  in   1        downstream accepts current beat
//   out_digit  out  4        current digit
//   out_last   out  1        current beat is digit 0
//   out_err    out  1        current digit is not legal BCD
// -----------------------------------------------------------------------------
module bcd_digit_serializer
    import bcd_digit_serializer_pkg::*;
#(
    parameter int DIGIT       = 2,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIGIT*4-1:0] BCD_code,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_digit,
    output logic               out_last,
    output logic               out_err
);

    localparam int             IDX_W   = idx_width(DIGIT);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGIT - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DIGIT*4-1:0]   r_hold;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_lz_idx;
    logic [IDX_W-1:0]     w_load_idx;
    logic                 w_load;
    logic                 w_dec;
    logic [3:0]           w_digit;

    bcd_digit_serializer_lz_detect #(
        .DIGIT (DIGIT),
        .IDX_W (IDX_W)
    ) u_lz_detect (
        .i_word (BCD_code),
        .o_idx  (w_lz_idx)
    );

    // Without suppression every word starts at the top digit.
    assign w_load_idx = (LZ_SUPPRESS != 0) ? w_lz_idx : IDX_TOP;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (r_idx == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Hold register is written only on accept, so it is stable under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold <= '0;
            r_idx  <= '0;
        end else if (w_load) begin
            r_hold <= BCD_code;
            r_idx  <= w_load_idx;
        end else if (w_dec) begin
            r_idx  <= r_idx - IDX_W'(1);
        end
    end

    always_comb begin
        w_digit = 4'd0;
        for (int k = 0; k < DIGIT; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_digit = r_hold[4*k +: 4];
            end
        end
    end

    // Beat outputs are forced to zero while idle.
    assign out_digit = out_valid ? w_digit : 4'd0;
    assign out_last  = out_valid && (r_idx == '0);
    assign out_err   = out_valid && (w_digit > BCD_MAX);

endmodule

// File: tb/tb_bcd_digit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bcd_digit_serializer
// Two DUT instances with DIGIT=4: u0 suppresses leading zeros, u1 does not.
// Expected beats are queued when a word is accepted; a negedge monitor
// compares every presented beat and the in_ready/out_valid status.
// -----------------------------------------------------------------------------
module tb_bcd_digit_serializer;

    typedef struct {
        logic [3:0] d;
        logic       last;
        logic       err;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid [2];
    logic        in_ready [2];
    logic [15:0] code     [2];
    logic        out_valid[2];
    logic        out_ready[2];
    logic [3:0]  out_digit[2];
    logic        out_last [2];
    logic        out_err  [2];

    int          rdy_mode [2];   // 0: always ready, 1: random, 2: stalled
    beat_t       q0[$];
    beat_t       q1[$];
    int          checks;
    int          errors;
    int          cyc;
    int          last_accept;
    int          prev_accept;

    bcd_digit_serializer #(.DIGIT(4), .LZ_SUPPRESS(1)) u0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .BCD_code  (code[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_digit (out_digit[0]),
        .out_last  (out_last[0]),
        .out_err   (out_err[0])
    );

    bcd_digit_serializer #(.DIGIT(4), .LZ_SUPPRESS(0)) u1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .BCD_code  (code[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_digit (out_digit[1]),
        .out_last  (out_last[1]),
        .out_err   (out_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [u%0d] at cycle %0d: got %0h expected %0h", nm, u, cyc, act, exp);
        end
    endtask

    function automatic int qsize(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    // Reference model: digits from the first one to send down to digit 0.
    task automatic push_model(input int u, input logic [15:0] w);
        int         top;
        logic [3:0] d;
        beat_t      b;
        top = 3;
        if (u == 0) begin
            while (top > 0 && w[4*top +: 4] == 4'd0) top--;
        end
        for (int k = top; k >= 0; k--) begin
            d      = w[4*k +: 4];
            b.d    = d;
            b.last = (k == 0);
            b.err  = (d > 4'd9);
            if (u == 0) q0.push_back(b);
            else        q1.push_back(b);
        end
    endtask

    // Downstream ready generator.
    always @(posedge clk) begin
        #1;
        for (int u = 0; u < 2; u++) begin
            case (rdy_mode[u])
                0:       out_ready[u] = 1'b1;
                1:       out_ready[u] = ($urandom_range(0, 3) != 0);
                default: out_ready[u] = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int u = 0; u < 2; u++) begin
                beat_t b;
                chk("in_ready", u, 32'(in_ready[u]), 32'(qsize(u) == 0));
                chk("out_valid", u, 32'(out_valid[u]), 32'(qsize(u) != 0));
                if (out_valid[u] && qsize(u) != 0) begin
                    b = (u == 0) ? q0[0] : q1[0];
                    chk("out_digit", u, 32'(out_digit[u]), 32'(b.d));
                    chk("out_last", u, 32'(out_last[u]), 32'(b.last));
                    chk("out_err", u, 32'(out_err[u]), 32'(b.err));
                    if (out_ready[u]) begin
                        if (u == 0) void'(q0.pop_front());
                        else        void'(q1.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int u, input logic [15:0] w);
        int n;
        code[u]     = w;
        in_valid[u] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready[u] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[u]) begin
            chk("accept_timeout", u, 32'(in_ready[u]), 32'd1);
            in_valid[u] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        prev_accept = last_accept;
        last_accept = cyc;
        push_model(u, w);
    endtask

    task automatic drain(input int u);
        int n;
        n = 0;
        while (qsize(u) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (qsize(u) != 0) chk("drain_timeout", u, 32'(qsize(u)), 32'd0);
        tick();
    endtask

    task automatic reset_checks();
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_out_digit", u, 32'(out_digit[u]), 32'd0);
            chk("rst_out_last", u, 32'(out_last[u]), 32'd0);
            chk("rst_out_err", u, 32'(out_err[u]), 32'd0);
        end
    endtask

    function automatic logic [3:0] rnd_nib();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4)      return 4'd0;
        else if (r < 8) return 4'($urandom_range(1, 9));
        else            return 4'($urandom_range(10, 15));
    endfunction

    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        last_accept = 0;
        prev_accept = 0;
        rst_n       = 1'b0;
        for (int u = 0; u < 2; u++) begin
            in_valid[u]  = 1'b0;
            code[u]      = 16'h0;
            out_ready[u] = 1'b1;
            rdy_mode[u]  = 0;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        reset_checks();
        tick();

        // Basic ordering and leading-zero handling on both flavours.
        send_word(0, 16'h0015); drain(0);
        send_word(0, 16'h0007); drain(0);
        send_word(0, 16'h0000); drain(0);
        send_word(1, 16'h0007); drain(1);
        send_word(1, 16'h0000); drain(1);

        // Backpressure on the first beat of 0x93.
        rdy_mode[0] = 2;
        send_word(0, 16'h0093);
        repeat (5) tick();
        rdy_mode[0] = 0;
        drain(0);

        // Illegal digits.
        send_word(0, 16'h001A); drain(0);
        send_word(0, 16'h00A0); drain(0);
        send_word(1, 16'hF0B1); drain(1);

        // Reset while the second digit of 0x1234 is on the output.
        send_word(0, 16'h1234);
        tick();
        rst_n = 1'b0;
        tick();
        q0.delete();
        q1.delete();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_out_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("post_rst_in_ready", 0, 32'(in_ready[0]), 32'd1);
        tick();
        send_word(0, 16'h0056); drain(0);

        // Back-to-back words with in_valid held: two beats plus one bubble.
        send_word(0, 16'h0042);
        send_word(0, 16'h0008);
        chk("b2b_accept_gap", 0, 32'(last_accept - prev_accept), 32'd3);
        drain(0);

        // Randomized traffic with random downstream stalls.
        rdy_mode[0] = 1;
        rdy_mode[1] = 1;
        for (int i = 0; i < 80; i++) begin
            logic [15:0] w;
            int          u;
            w = {rnd_nib(), rnd_nib(), rnd_nib(), rnd_nib()};
            u = $urandom_range(0, 1);
            send_word(u, w);
            if ($urandom_range(0, 3) == 0) drain(u);
        end
        drain(0);
        drain(1);
        rdy_mode[0] = 0;
        rdy_mode[1] = 0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
